// File: rtl/bus_trace_buffer_pkg.sv
// Shared definitions for the bus trace buffer: FSM state encodings and entry field offsets.
package bus_trace_buffer_pkg;

   typedef enum logic [1:0] {
      TRC_IDLE  = 2'd0,
      TRC_ARMED = 2'd1,
      TRC_POST  = 2'd2,
      TRC_READ  = 2'd3
   } trc_state_e;

   // Entry layout is {sync, rw, ab, db}, db in the least significant bits.
   function automatic int unsigned trc_entry_width(int unsigned aw, int unsigned dw);
      return aw + dw + 2;
   endfunction

   function automatic int unsigned trc_sync_bit(int unsigned aw, int unsigned dw);
      return aw + dw + 1;
   endfunction

   function automatic int unsigned trc_rw_bit(int unsigned aw, int unsigned dw);
      return aw + dw;
   endfunction

   function automatic int unsigned trc_ab_lsb(int unsigned dw);
      return dw;
   endfunction

endpackage

// File: rtl/bus_trace_buffer_if.sv
// Sampled CPU bus plus the valid/ready readout port of the trace buffer.
interface bus_trace_buffer_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 8
);
   localparam int unsigned EW = AW + DW + 2;

   logic          sample_en;
   logic [AW-1:0] bus_ab;
   logic [DW-1:0] bus_db;
   logic          bus_rw;
   logic          bus_sync;
   logic [EW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready;

   modport master (
      output sample_en, bus_ab, bus_db, bus_rw, bus_sync, rd_ready,
      input  rd_data, rd_valid
   );

   modport slave (
      input  sample_en, bus_ab, bus_db, bus_rw, bus_sync, rd_ready,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/bus_trace_buffer_trace_ram.sv
// DEPTH x EW flop array: one synchronous write port, one asynchronous read port, no reset.
module bus_trace_buffer_trace_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned EW    = 26,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [EW-1:0] wdata,
   input  logic [PW-1:0] raddr,
   output logic [EW-1:0] rdata
);

   logic [EW-1:0] mem_q [DEPTH];

   // Capture write; contents survive reset and abort by design.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_trace_buffer.sv
// Triggerable circular capture of bus cycles with pre/post-trigger windowing and oldest-first readout.
module bus_trace_buffer
   import bus_trace_buffer_pkg::*;
#(
   parameter int unsigned AW    = 16,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 64,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   bus_trace_buffer_if.slave    bus,
   input  logic                 arm,
   input  logic                 abort,
   input  logic [AW-1:0]        trig_addr,
   input  logic [AW-1:0]        trig_mask,
   input  logic                 trig_on_sync,
   input  logic [PW-1:0]        post_count,
   output logic                 busy,
   output logic                 triggered,
   output logic [PW:0]          fill_count,
   output logic [PW-1:0]        trig_pos,
   output logic                 done
);

   localparam int unsigned FW       = PW + 1;
   localparam int unsigned EW       = trc_entry_width(AW, DW);
   localparam int unsigned SYNC_BIT = trc_sync_bit(AW, DW);
   localparam int unsigned RW_BIT   = trc_rw_bit(AW, DW);
   localparam int unsigned AB_LSB   = trc_ab_lsb(DW);

   trc_state_e    state_q, state_d;
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [FW-1:0] remain_q, remain_d;
   logic [PW-1:0] post_left_q, post_left_d;
   logic [PW-1:0] post_lat_q, post_lat_d;
   logic [PW-1:0] trig_pos_q, trig_pos_d;
   logic          done_q, done_d;

   logic          hit;
   logic          wr_en;
   logic          enter_read;
   logic [FW-1:0] fill_inc;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] ram_rdata;

   // Address/sync trigger compare on the live bus.
   assign hit = bus.sample_en
              & (((bus.bus_ab ^ trig_addr) & trig_mask) == '0)
              & (~trig_on_sync | bus.bus_sync);

   assign fill_inc = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);

   // Pack the sampled bus cycle into a trace entry.
   always_comb begin
      wr_entry                   = '0;
      wr_entry[SYNC_BIT]         = bus.bus_sync;
      wr_entry[RW_BIT]           = bus.bus_rw;
      wr_entry[AB_LSB +: AW]     = bus.bus_ab;
      wr_entry[DW-1:0]           = bus.bus_db;
   end

   // Next-state, pointer and counter logic.
   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      fill_d      = fill_q;
      remain_d    = remain_q;
      post_left_d = post_left_q;
      post_lat_d  = post_lat_q;
      trig_pos_d  = trig_pos_q;
      done_d      = 1'b0;
      wr_en       = 1'b0;
      enter_read  = 1'b0;

      unique case (state_q)
         TRC_IDLE: begin
            if (arm) begin
               state_d     = TRC_ARMED;
               wp_d        = '0;
               rp_d        = '0;
               fill_d      = '0;
               post_left_d = post_count;
               post_lat_d  = post_count;
            end
         end
         TRC_ARMED: begin
            if (bus.sample_en) begin
               wr_en  = 1'b1;
               wp_d   = wp_q + PW'(1);
               fill_d = fill_inc;
               if (hit) begin
                  if (post_left_q == '0) begin
                     enter_read = 1'b1;
                  end else begin
                     state_d = TRC_POST;
                  end
               end
            end
         end
         TRC_POST: begin
            if (bus.sample_en) begin
               wr_en       = 1'b1;
               wp_d        = wp_q + PW'(1);
               fill_d      = fill_inc;
               post_left_d = post_left_q - PW'(1);
               if (post_left_q == PW'(1)) begin
                  enter_read = 1'b1;
               end
            end
         end
         TRC_READ: begin
            if (bus.rd_ready) begin
               rp_d     = rp_q + PW'(1);
               remain_d = remain_q - FW'(1);
               if (remain_q == FW'(1)) begin
                  state_d = TRC_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = TRC_IDLE;
      endcase

      // Oldest held entry starts the readout; a full buffer wraps rp onto wp.
      if (enter_read) begin
         state_d    = TRC_READ;
         rp_d       = wp_d - PW'(fill_d);
         remain_d   = fill_d;
         trig_pos_d = PW'(fill_d - FW'(1) - FW'(post_lat_q));
      end

      // Abort wins over everything, including a simultaneous arm or write.
      if (abort) begin
         state_d     = TRC_IDLE;
         wp_d        = wp_q;
         rp_d        = rp_q;
         fill_d      = fill_q;
         remain_d    = remain_q;
         post_left_d = post_left_q;
         post_lat_d  = post_lat_q;
         trig_pos_d  = trig_pos_q;
         done_d      = 1'b0;
         wr_en       = 1'b0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= TRC_IDLE;
         wp_q        <= '0;
         rp_q        <= '0;
         fill_q      <= '0;
         remain_q    <= '0;
         post_left_q <= '0;
         post_lat_q  <= '0;
         trig_pos_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         fill_q      <= fill_d;
         remain_q    <= remain_d;
         post_left_q <= post_left_d;
         post_lat_q  <= post_lat_d;
         trig_pos_q  <= trig_pos_d;
         done_q      <= done_d;
      end
   end

   bus_trace_buffer_trace_ram #(
      .DEPTH (DEPTH),
      .EW    (EW)
   ) u_trace_ram (
      .clock (clock),
      .we    (wr_en),
      .waddr (wp_q),
      .wdata (wr_entry),
      .raddr (rp_q),
      .rdata (ram_rdata)
   );

   assign bus.rd_valid = (state_q == TRC_READ);
   assign bus.rd_data  = (state_q == TRC_READ) ? ram_rdata : '0;
   assign busy         = (state_q != TRC_IDLE);
   assign triggered    = (state_q == TRC_POST) || (state_q == TRC_READ);
   assign fill_count   = fill_q;
   assign trig_pos     = trig_pos_q;
   assign done         = done_q;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Randomised and directed bench for bus_trace_buffer against a queue-based capture model.
module tb_bus_trace_buffer;

   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = 4;
   localparam int unsigned EW    = AW + DW + 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          arm;
   logic          abort;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] trig_mask;
   logic          trig_on_sync;
   logic [PW-1:0] post_count;
   logic          busy;
   logic          triggered;
   logic [PW:0]   fill_count;
   logic [PW-1:0] trig_pos;
   logic          done;

   bus_trace_buffer_if #(.AW(AW), .DW(DW)) bus_if ();

   bus_trace_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus_if.slave),
      .arm          (arm),
      .abort        (abort),
      .trig_addr    (trig_addr),
      .trig_mask    (trig_mask),
      .trig_on_sync (trig_on_sync),
      .post_count   (post_count),
      .busy         (busy),
      .triggered    (triggered),
      .fill_count   (fill_count),
      .trig_pos     (trig_pos),
      .done         (done)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 waiting for trigger, 2 collecting post samples, 3 reading out
   int            m_phase    = 0;
   logic [EW-1:0] m_q[$];
   bit            m_tq[$];
   int            m_post_lat = 0;
   int            m_left     = 0;
   int            m_idx      = 0;
   int            m_trig_pos = 0;
   bit            m_done     = 0;
   bit            started    = 0;

   function automatic bit m_hit();
      return bus_if.sample_en && (((bus_if.bus_ab ^ trig_addr) & trig_mask) == 16'h0)
             && (!trig_on_sync || bus_if.bus_sync);
   endfunction

   function automatic logic [EW-1:0] m_entry();
      return {bus_if.bus_sync, bus_if.bus_rw, bus_if.bus_ab, bus_if.bus_db};
   endfunction

   task automatic m_push(input logic [EW-1:0] e, input bit h);
      m_q.push_back(e);
      m_tq.push_back(h);
      if (m_q.size() > DEPTH) begin
         void'(m_q.pop_front());
         void'(m_tq.pop_front());
      end
   endtask

   task automatic m_enter_read();
      m_phase = 3;
      m_idx   = 0;
      foreach (m_tq[i]) if (m_tq[i]) m_trig_pos = i;
   endtask

   always @(posedge clock) begin
      started = 1;
      m_done  = 0;
      if (reset) begin
         m_phase = 0;
         m_q.delete();
         m_tq.delete();
         m_trig_pos = 0;
      end else if (abort) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (arm) begin
               m_phase = 1;
               m_q.delete();
               m_tq.delete();
               m_post_lat = int'(post_count);
               m_left     = int'(post_count);
            end
            1: if (bus_if.sample_en) begin
               bit h;
               h = m_hit();
               m_push(m_entry(), h);
               if (h) begin
                  if (m_left == 0) m_enter_read();
                  else m_phase = 2;
               end
            end
            2: if (bus_if.sample_en) begin
               m_push(m_entry(), 1'b0);
               m_left--;
               if (m_left == 0) m_enter_read();
            end
            default: if (bus_if.rd_ready) begin
               m_idx++;
               if (m_idx == m_q.size()) begin
                  m_phase = 0;
                  m_done  = 1;
               end
            end
         endcase
      end
   end

   // Cycle-by-cycle comparison on the falling edge.
   always @(negedge clock) begin
      if (started) begin
         logic [EW-1:0] exp_data;
         exp_data = '0;
         if (m_phase == 3 && m_idx < m_q.size()) exp_data = m_q[m_idx];
         chk("busy",       busy,            m_phase != 0);
         chk("triggered",  triggered,       m_phase >= 2);
         chk("rd_valid",   bus_if.rd_valid, m_phase == 3);
         chk("rd_data",    bus_if.rd_data,  exp_data);
         chk("fill_count", fill_count,      m_q.size());
         chk("trig_pos",   trig_pos,        m_trig_pos);
         chk("done",       done,            m_done);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic set_bus(input bit en, input logic [15:0] ab, input logic [7:0] db,
                          input bit rw, input bit sync);
      bus_if.sample_en = en;
      bus_if.bus_ab    = ab;
      bus_if.bus_db    = db;
      bus_if.bus_rw    = rw;
      bus_if.bus_sync  = sync;
   endtask

   task automatic do_arm(input int post, input logic [15:0] addr, input logic [15:0] mask,
                         input bit on_sync);
      post_count   = PW'(post);
      trig_addr    = addr;
      trig_mask    = mask;
      trig_on_sync = on_sync;
      arm          = 1'b1;
      step();
      arm          = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic drain(input int mode, output int accepts);
      accepts = 0;
      for (int i = 0; i < 400 && bus_if.rd_valid; i++) begin
         case (mode)
            0:       bus_if.rd_ready = 1'b1;
            1:       bus_if.rd_ready = (i % 3 == 0);
            default: bus_if.rd_ready = 1'($urandom_range(0, 1));
         endcase
         if (bus_if.rd_ready) accepts++;
         step();
      end
      bus_if.rd_ready = 1'b0;
      chk("drain_finished", bus_if.rd_valid, 1'b0);
   endtask

   initial begin
      logic [EW-1:0] e;
      int            acc;

      reset = 1'b1; arm = 1'b0; abort = 1'b0;
      trig_addr = '0; trig_mask = '0; trig_on_sync = 1'b0; post_count = '0;
      bus_if.rd_ready = 1'b0;
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      step();
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_triggered", triggered, 1'b0);
      chk("rst_rd_valid", bus_if.rd_valid, 1'b0);
      chk("rst_rd_data", bus_if.rd_data, 0);
      chk("rst_fill", fill_count, 0);
      chk("rst_trig_pos", trig_pos, 0);
      chk("rst_done", done, 1'b0);
      reset = 1'b0;
      step();

      // Window around an exact address trigger with wrap.
      do_arm(4, 16'h0010, 16'hFFFF, 1'b0);
      for (int a = 0; a <= 32; a++) begin
         set_bus(1'b1, 16'(a), 8'(a), 1'($urandom_range(0, 1)), 1'b0);
         step();
      end
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      e = bus_if.rd_data;
      chk("s2_fill", fill_count, 16);
      chk("s2_trig_pos", trig_pos, 11);
      chk("s2_first_ab", e[DW +: AW], 16'h0005);
      chk("s2_first_db", e[DW-1:0], 8'h05);
      drain(0, acc);
      chk("s2_accepts", acc, 16);
      chk("s2_done_pulse", done, 1'b1);
      step();

      // Trigger on the second sample, stalled readout.
      do_arm(3, 16'h0001, 16'hFFFF, 1'b0);
      for (int a = 0; a < 10; a++) begin
         set_bus(1'b1, 16'(a), 8'(a + 8'h40), 1'b1, 1'b0);
         step();
      end
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      e = bus_if.rd_data;
      chk("s3_fill", fill_count, 5);
      chk("s3_trig_pos", trig_pos, 1);
      chk("s3_first_ab", e[DW +: AW], 16'h0000);
      drain(1, acc);
      chk("s3_accepts", acc, 5);

      // Trigger qualified by SYNC.
      do_arm(2, 16'hFFFC, 16'hFFFF, 1'b1);
      set_bus(1'b1, 16'h0100, 8'h11, 1'b1, 1'b0); step();
      set_bus(1'b1, 16'hFFFC, 8'h22, 1'b1, 1'b0); step();
      chk("s4_not_trig", triggered, 1'b0);
      set_bus(1'b1, 16'h0101, 8'h33, 1'b1, 1'b0); step();
      set_bus(1'b1, 16'hFFFC, 8'h44, 1'b1, 1'b1); step();
      chk("s4_trig", triggered, 1'b1);
      set_bus(1'b1, 16'h0200, 8'h55, 1'b0, 1'b0); step();
      set_bus(1'b1, 16'h0201, 8'h66, 1'b0, 1'b0); step();
      set_bus(1'b1, 16'h0300, 8'h77, 1'b0, 1'b0); step();
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      chk("s4_fill", fill_count, 6);
      chk("s4_trig_pos", trig_pos, 3);
      drain(2, acc);

      // Reset in the middle of readout.
      do_arm(1, 16'h0002, 16'hFFFF, 1'b0);
      for (int a = 0; a < 6; a++) begin
         set_bus(1'b1, 16'(a), 8'(a), 1'b0, 1'b0);
         step();
      end
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      bus_if.rd_ready = 1'b1;
      step();
      bus_if.rd_ready = 1'b0;
      reset = 1'b1;
      step();
      chk("s5_rd_valid", bus_if.rd_valid, 1'b0);
      chk("s5_busy", busy, 1'b0);
      chk("s5_fill", fill_count, 0);
      chk("s5_rd_data", bus_if.rd_data, 0);
      reset = 1'b0;
      step();

      // Maximum post count, first sample triggers, sparse qualifier.
      do_arm(15, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 40 && !bus_if.rd_valid; i++) begin
         set_bus(i % 2 == 0, 16'(i + 16'h0A00), 8'(i), 1'b1, 1'b0);
         step();
      end
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      e = bus_if.rd_data;
      chk("s6_fill", fill_count, 16);
      chk("s6_trig_pos", trig_pos, 0);
      chk("s6_first_ab", e[DW +: AW], 16'h0A00);
      drain(0, acc);
      chk("s6_accepts", acc, 16);

      // Abort beats arm; abort while armed.
      arm = 1'b1; abort = 1'b1;
      step();
      arm = 1'b0; abort = 1'b0;
      chk("s7_abort_arm", busy, 1'b0);
      do_arm(2, 16'h1234, 16'hFFFF, 1'b0);
      chk("s7_armed", busy, 1'b1);
      set_bus(1'b1, 16'h0001, 8'h01, 1'b0, 1'b0); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      set_bus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      chk("s7_aborted", busy, 1'b0);
      step();

      // Randomised captures.
      for (int r = 0; r < 30; r++) begin
         do_arm(int'($urandom_range(0, 15)), 16'($urandom),
                16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) == 0));
         for (int i = 0; i < 300 && !bus_if.rd_valid; i++) begin
            set_bus($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            abort = ($urandom_range(0, 199) == 0);
            arm   = ($urandom_range(0, 15) == 0);
            step();
         end
         abort = 1'b0;
         arm   = 1'b0;
         if (!bus_if.rd_valid) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
         end
         set_bus(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 1'b0, 1'b1);
         drain(2, acc);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bus_trace_buffer.md
# bus_trace_buffer

Parametrised, triggerable capture buffer for the external bus of `top_6502C`, synthesisable for in-system debug and usable in simulation alongside `memory256x256`. While armed it records one entry per qualified bus cycle (address, data, RW, SYNC) into a circular store. On an address-match trigger it records a programmable number of further samples, then streams the window out, oldest first, over a valid/ready port. It generalises the per-cycle bus printout in the CPU bench into configurable-width, configurable-depth hardware with pre/post-trigger windowing.

## Interface
- `AW`, 16, address width
- `DW`, 8, data width
- `DEPTH`, 64, entries; power of two, ≥4; `PW = log2(DEPTH)`
- Entry width `EW = AW+DW+2`, packed as {sync, rw, ab, db}
- `clock`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `sample_en`  in  1  bus-cycle qualifier; one entry per cycle with `sample_en`=1
- `bus_ab`  in  AW  address bus
- `bus_db`  in  DW  data bus
- `bus_rw`  in  1  1 = read
- `bus_sync`  in  1  opcode-fetch marker
- `arm`  in  1  start capture (honoured only in IDLE)
- `abort`  in  1  return to IDLE from any state
- `trig_addr`  in  AW  trigger address
- `trig_mask`  in  AW  1 = bit compared
- `trig_on_sync`  in  1  also require `bus_sync`=1
- `post_count`  in  PW  samples after the trigger sample; latched at `arm`
- `rd_data`  out  EW  current entry; 0 when `rd_valid`=0
- `rd_valid`  out  1  entry available
- `rd_ready`  in  1  consumer accepts
- `busy`  out  1  state ≠ IDLE
- `triggered`  out  1  state is POST or READOUT
- `fill_count`  out  PW+1  entries held (0..DEPTH)
- `trig_pos`  out  PW  readout index of the trigger entry
- `done`  out  1  one-cycle pulse after the last entry is accepted

## Operation
- States: IDLE, ARMED, POST, READOUT.
- IDLE → ARMED on `arm`. Clears `wp`, `fill`, `rp`. Latches `post_count` into `post_left`.
- Hit = `sample_en` & (((`bus_ab`^`trig_addr`)&`trig_mask`)==0) & (!`trig_on_sync` | `bus_sync`).
- ARMED: each `sample_en` writes entry at `wp`; `wp` increments mod DEPTH; `fill` saturates at DEPTH.
  - Hit: trigger entry is written.
  - Next state is POST, or READOUT if `post_left`=0.
- POST: each `sample_en` writes an entry and decrements `post_left`. The write that takes `post_left` 1→0 moves the state to READOUT. Hits in POST are ignored.
- On entering READOUT:
  - `rp` = (`wp` − `fill`) mod DEPTH.
  - `trig_pos` = `fill` − 1 − latched post count.
- READOUT: `rd_valid`=1, `rd_data`=mem[`rp`].
  - On `rd_valid`&`rd_ready`: `rp`++ and remaining count--.
  - After the last accept, state → IDLE and `done` pulses.
- `abort` (and `reset`) → IDLE immediately. `abort` beats a simultaneous `arm`. Memory contents are not cleared.
- `arm` outside IDLE is ignored.
- Bus inputs are ignored in IDLE and READOUT.
- Post ≤ DEPTH−1, so the trigger entry is never overwritten.
  - Pre-trigger entries kept = min(pre-trigger samples, DEPTH−1−post).
- Trigger on the very first sample: `trig_pos`=0.

## Timing
- After reset: state IDLE; `busy`, `triggered`, `rd_valid`, `done` = 0; `rd_data`=0; `fill_count`=0; `trig_pos`=0.
- `arm` at edge n → ARMED at n+1. First capturable sample is in cycle n+1.
- A sample presented in cycle k is written at edge k.
- A trigger at edge k gives `triggered`=1 from k+1.
- The final write at edge k gives READOUT and `rd_valid`=1 from k+1.
- Readout has no added latency (asynchronous array read) and sustains one entry per cycle with `rd_ready` held high.
- `rd_data` is stable while `rd_valid`=1 and `rd_ready`=0.
- `done` is high in the cycle following the last accept, concurrent with IDLE.

## Structure
- Shared include `Debug/TraceDef.v`: state encodings (`TRC_IDLE`, `TRC_ARMED`, `TRC_POST`, `TRC_READ`) and entry field offsets (`TRC_SYNC`, `TRC_RW`, AB/DB slices as functions of AW/DW).
- Sub-module `trace_ram`: DEPTH×EW flop array, one synchronous write port, one asynchronous read port, no reset.
- Top block holds the FSM, pointers, counters and trigger compare.

## Test plan
All scenarios use DEPTH=16, AW=16, DW=8.
- Reset mid-READOUT → next cycle `rd_valid`=0, `busy`=0, `fill_count`=0, `rd_data`=0.
- Arm, post=4, mask FFFF, `trig_addr`=0x0010; feed ab=0x0000..0x0020, one per cycle, db=ab[7:0] → 16 entries ab 0x0005..0x0014, `trig_pos`=11, `done` after 16th accept.
- Arm, post=3, trigger on the second sample (ab=0x0001) → `fill_count`=5, first entry ab=0x0000, `trig_pos`=1.
- `trig_on_sync`=1, ab=0xFFFC seen with sync=0 then sync=1 → only the sync=1 occurrence triggers; `trig_pos` points to it.
- READOUT with `rd_ready` toggling 1,0,0,1… → no entry duplicated or dropped; `rd_data` held during stalls.
- Post=15 with `sample_en` low on alternate cycles → exactly 16 entries, trigger at `trig_pos`=0. `arm` and `abort` in the same cycle → stays IDLE.
